// File: rtl/transpose_controller_if.sv
// Row-in / column-out handshakes plus the bank-side write and read ports of the
// transpose controller, bundled so the controller and its environment share one definition.
interface transpose_controller_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PE     = 4,
   parameter int ADDR_WIDTH = 3
);
   logic                                 in_valid;
   logic                                 in_ready;
   logic [NUM_PE-1:0][DATA_WIDTH-1:0]    in_data;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [NUM_PE-1:0][DATA_WIDTH-1:0]    out_data;
   logic                                 out_last;
   logic                                 wen;
   logic [NUM_PE-1:0][ADDR_WIDTH-1:0]    write_addr;
   logic [NUM_PE-1:0][DATA_WIDTH-1:0]    write_data;
   logic                                 ren;
   logic [NUM_PE-1:0][ADDR_WIDTH-1:0]    read_addr;
   logic [NUM_PE-1:0][DATA_WIDTH-1:0]    read_data;

   modport master (
      input  in_valid, in_data, out_ready, read_data,
      output in_ready, out_valid, out_data, out_last,
             wen, write_addr, write_data, ren, read_addr
   );

   modport slave (
      output in_valid, in_data, out_ready, read_data,
      input  in_ready, out_valid, out_data, out_last,
             wen, write_addr, write_data, ren, read_addr
   );
endinterface

// File: rtl/transpose_controller.sv
// Tile transpose sequencer: rows are written diagonally skewed across NUM_PE banks so each
// column reads back in one access; two ping-pong buffers and a 2-entry output FIFO.

// Per-bank rotation: write skew, read address skew and output lane un-rotation for one lane.
module transpose_lane #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PE     = 4,
   parameter int ADDR_WIDTH = 3,
   parameter int LANE       = 0
) (
   input  logic [$clog2(NUM_PE)-1:0]         r,
   input  logic [$clog2(NUM_PE)-1:0]         c,
   input  logic [$clog2(NUM_PE)-1:0]         tag_c,
   input  logic                              wbuf,
   input  logic                              rbuf,
   input  logic [NUM_PE-1:0][DATA_WIDTH-1:0] in_data,
   input  logic [NUM_PE-1:0][DATA_WIDTH-1:0] read_data,
   output logic [ADDR_WIDTH-1:0]             write_addr,
   output logic [DATA_WIDTH-1:0]             write_data,
   output logic [ADDR_WIDTH-1:0]             read_addr,
   output logic [DATA_WIDTH-1:0]             col_elem
);
   localparam int CW = $clog2(NUM_PE);
   localparam logic [CW-1:0] ID = CW'(LANE);

   logic [CW-1:0] src_col;
   logic [CW-1:0] rd_row;
   logic [CW-1:0] bank_sel;

   // NUM_PE is a power of two, so the CW-bit subtract/add is the mod-NUM_PE rotation.
   assign src_col  = ID - r;
   assign rd_row   = ID - c;
   assign bank_sel = tag_c + ID;

   assign write_addr = {wbuf, r};
   assign write_data = in_data[src_col];
   assign read_addr  = {rbuf, rd_row};
   assign col_elem   = read_data[bank_sel];
endmodule

module transpose_controller #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PE     = 4,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   transpose_controller_if.master bus
);
   localparam int CW = $clog2(NUM_PE);
   localparam logic [CW-1:0] LAST = CW'(NUM_PE - 1);

   typedef logic [NUM_PE-1:0][DATA_WIDTH-1:0] vec_t;

   logic [1:0]    full;
   logic [1:0]    full_nxt;
   logic          wbuf;
   logic          rbuf;
   logic [CW-1:0] r;
   logic [CW-1:0] c;
   logic [CW-1:0] tag_c;
   logic          tag_last;
   logic          inflight;

   logic [1:0]    fifo_cnt;
   logic          fifo_wp;
   logic          fifo_rp;
   vec_t          fifo_data [2];
   logic [1:0]    fifo_last;

   logic          pop;
   logic          wr_done;
   logic          rd_done;
   logic [2:0]    occ;

   vec_t                              col;
   logic [NUM_PE-1:0][ADDR_WIDTH-1:0] wa;
   logic [NUM_PE-1:0][ADDR_WIDTH-1:0] ra;
   vec_t                              wd;

   for (genvar g = 0; g < NUM_PE; g++) begin : g_lane
      transpose_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_PE     (NUM_PE),
         .ADDR_WIDTH (ADDR_WIDTH),
         .LANE       (g)
      ) u_lane (
         .r          (r),
         .c          (c),
         .tag_c      (tag_c),
         .wbuf       (wbuf),
         .rbuf       (rbuf),
         .in_data    (bus.in_data),
         .read_data  (bus.read_data),
         .write_addr (wa[g]),
         .write_data (wd[g]),
         .read_addr  (ra[g]),
         .col_elem   (col[g])
      );
   end

   assign bus.write_addr = wa;
   assign bus.write_data = wd;
   assign bus.read_addr  = ra;

   assign bus.in_ready = !full[wbuf];
   assign bus.wen      = bus.in_valid && !full[wbuf];

   assign bus.out_valid = (fifo_cnt != 2'd0);
   assign bus.out_data  = fifo_data[fifo_rp];
   assign bus.out_last  = fifo_last[fifo_rp];
   assign pop           = bus.out_valid && bus.out_ready;

   // Only issue a read when its column is guaranteed a FIFO slot on arrival.
   assign occ     = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
   assign bus.ren = full[rbuf] && (occ < 3'd2);

   assign wr_done = bus.wen && (r == LAST);
   assign rd_done = bus.ren && (c == LAST);

   // wr_done needs !full[wbuf] and rd_done needs full[rbuf], so they never hit the same buffer.
   always_comb begin
      full_nxt = full;
      if (wr_done) full_nxt[wbuf] = 1'b1;
      if (rd_done) full_nxt[rbuf] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full     <= 2'b00;
         wbuf     <= 1'b0;
         rbuf     <= 1'b0;
         r        <= '0;
         c        <= '0;
      end else begin
         full <= full_nxt;
         if (bus.wen) begin
            r <= r + CW'(1);
            if (r == LAST) wbuf <= ~wbuf;
         end
         if (bus.ren) begin
            c <= c + CW'(1);
            if (c == LAST) rbuf <= ~rbuf;
         end
      end
   end

   // Issue tag travels alongside the registered bank read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= 1'b0;
         tag_c    <= '0;
         tag_last <= 1'b0;
      end else begin
         inflight <= bus.ren;
         if (bus.ren) begin
            tag_c    <= c;
            tag_last <= (c == LAST);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo_cnt  <= 2'd0;
         fifo_wp   <= 1'b0;
         fifo_rp   <= 1'b0;
         fifo_last <= 2'b00;
      end else begin
         fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
         if (inflight) begin
            fifo_last[fifo_wp] <= tag_last;
            fifo_wp            <= ~fifo_wp;
         end
         if (pop) fifo_rp <= ~fifo_rp;
      end
   end

   always_ff @(posedge clk) begin
      if (inflight) fifo_data[fifo_wp] <= col;
   end
endmodule

// File: tb/tb_transpose_controller.sv
// Directed bench for transpose_controller with a registered-read bank model and column scoreboard.
module tb_transpose_controller;
   localparam int DW = 16;
   localparam int N  = 4;
   localparam int AW = 3;

   typedef logic [N-1:0][DW-1:0] col_t;
   typedef logic [N-1:0][AW-1:0] addr_t;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   transpose_controller_if #(.DATA_WIDTH(DW), .NUM_PE(N), .ADDR_WIDTH(AW)) bus ();

   transpose_controller #(.DATA_WIDTH(DW), .NUM_PE(N), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] mem [N][1<<AW];
   always @(posedge clk) begin
      for (int b = 0; b < N; b++) begin
         if (bus.wen) mem[b][bus.write_addr[b]] <= bus.write_data[b];
         if (bus.ren) bus.read_data[b] <= mem[b][bus.read_addr[b]];
      end
   end

   col_t got_d [$];
   logic got_l [$];
   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         got_d.push_back(bus.out_data);
         got_l.push_back(bus.out_last);
      end
   end

   function automatic logic [DW-1:0] elem(int t, int rr, int cc);
      return DW'(t * 16 + 4 * rr + cc + 1);
   endfunction

   function automatic col_t col_exp(int t, int cc);
      col_t v;
      for (int rr = 0; rr < N; rr++) v[rr] = elem(t, rr, cc);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_row(int t, int rr);
      bus.in_valid = 1'b1;
      for (int cc = 0; cc < N; cc++) bus.in_data[cc] = elem(t, rr, cc);
   endtask

   task automatic send_row(int t, int rr);
      int k;
      set_row(t, rr);
      k = 0;
      @(negedge clk);
      while (!bus.in_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk($sformatf("accept_t%0d_r%0d", t, rr), 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_tiles(int t0, int nt, string tag);
      int   k;
      col_t d;
      logic l;
      k = 0;
      while (got_d.size() < nt * N && k < 4000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_count"}, 64'(got_d.size()), 64'(nt * N));
      for (int t = 0; t < nt; t++) begin
         for (int cc = 0; cc < N; cc++) begin
            if (got_d.size() != 0) begin
               d = got_d.pop_front();
               l = got_l.pop_front();
               chk($sformatf("%s_t%0d_c%0d_data", tag, t0 + t, cc), d, col_exp(t0 + t, cc));
               chk($sformatf("%s_t%0d_c%0d_last", tag, t0 + t, cc), 64'(l), 64'(cc == N - 1));
            end
         end
      end
      got_d.delete();
      got_l.delete();
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   addr_t wa_exp;
   addr_t ra_exp;
   col_t  wd_exp;

   initial begin
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      wa_exp = {3'd1, 3'd1, 3'd1, 3'd1};
      wd_exp = {16'd7, 16'd6, 16'd5, 16'd8};
      ra_exp = {3'd3, 3'd2, 3'd1, 3'd0};

      // Reset state
      #1;
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_wen",       64'(bus.wen),       64'd0);
      chk("rst_ren",       64'(bus.ren),       64'd0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // Single tile, bank mapping, first-read addresses and latency
      bus.out_ready = 1'b1;
      send_row(0, 0);
      set_row(0, 1);
      @(negedge clk);
      chk("map_wen",        64'(bus.wen),        64'd1);
      chk("map_write_addr", 64'(bus.write_addr), 64'(wa_exp));
      chk("map_write_data", bus.write_data,      wd_exp);
      tick();
      send_row(0, 2);
      send_row(0, 3);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("first_ren",       64'(bus.ren),       64'd1);
      chk("first_read_addr", 64'(bus.read_addr), 64'(ra_exp));
      chk("lat_ovalid_c1",   64'(bus.out_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("lat_ovalid_c2",   64'(bus.out_valid), 64'd0);
      tick();
      @(negedge clk);
      chk("lat_ovalid_c3",   64'(bus.out_valid), 64'd1);
      check_tiles(0, 1, "s1");

      // Three tiles back-to-back with the consumer stalled
      tick();
      bus.out_ready = 1'b0;
      for (int rr = 0; rr < 8; rr++) send_row(1 + rr / 4, rr % 4);
      set_row(3, 0);
      @(negedge clk);
      chk("s3_in_ready_full", 64'(bus.in_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk("s3_ren_stalled",   64'(bus.ren),       64'd0);
      chk("s3_out_valid",     64'(bus.out_valid), 64'd1);
      chk("s3_head",          bus.out_data,       col_exp(1, 0));
      tick();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("s3_ren_c2",        64'(bus.ren),       64'd1);
      chk("s3_in_ready_c2",   64'(bus.in_ready),  64'd0);
      tick();
      @(negedge clk);
      chk("s3_ren_c3",        64'(bus.ren),       64'd1);
      chk("s3_in_ready_c3",   64'(bus.in_ready),  64'd0);
      tick();
      @(negedge clk);
      chk("s3_in_ready_rise", 64'(bus.in_ready),  64'd1);
      tick();
      for (int rr = 1; rr < 4; rr++) send_row(3, rr);
      bus.in_valid = 1'b0;
      check_tiles(1, 3, "s3");

      // Consumer held off: head column stays put, nothing lost
      tick();
      bus.out_ready = 1'b0;
      for (int rr = 0; rr < 4; rr++) send_row(0, rr);
      bus.in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("s4_out_valid",   64'(bus.out_valid), 64'd1);
      chk("s4_head_a",      bus.out_data,       col_exp(0, 0));
      chk("s4_ren_a",       64'(bus.ren),       64'd0);
      repeat (4) @(negedge clk);
      chk("s4_head_b",      bus.out_data,       col_exp(0, 0));
      chk("s4_ren_b",       64'(bus.ren),       64'd0);
      chk("s4_none_taken",  64'(got_d.size()),  64'd0);
      tick();
      bus.out_ready = 1'b1;
      check_tiles(0, 1, "s4");

      // Reset with one buffered tile and a partial tile in progress
      tick();
      bus.out_ready = 1'b0;
      for (int rr = 0; rr < 4; rr++) send_row(6, rr);
      send_row(7, 0);
      send_row(7, 1);
      bus.in_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk("s5_out_valid", 64'(bus.out_valid), 64'd0);
      chk("s5_in_ready",  64'(bus.in_ready),  64'd1);
      chk("s5_wen",       64'(bus.wen),       64'd0);
      chk("s5_ren",       64'(bus.ren),       64'd0);
      tick(); tick();
      rst = 1'b1;
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("s5_no_stale",  64'(bus.out_valid), 64'd0);
      chk("s5_no_ren",    64'(bus.ren),       64'd0);
      tick();
      for (int rr = 0; rr < 4; rr++) send_row(0, rr);
      bus.in_valid = 1'b0;
      check_tiles(0, 1, "s5");

      // Random producer gaps and consumer backpressure over 20 tiles
      tick();
      fork
         begin
            for (int t = 10; t < 30; t++) begin
               for (int rr = 0; rr < N; rr++) begin
                  if ($urandom_range(0, 2) == 0) begin
                     bus.in_valid = 1'b0;
                     tick();
                  end
                  send_row(t, rr);
               end
            end
            bus.in_valid = 1'b0;
         end
         begin
            for (int k = 0; k < 6000 && got_d.size() < 20 * N; k++) begin
               tick();
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      check_tiles(10, 20, "s6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
